// File: rtl/vram_bram_fb.sv
// Block-RAM framebuffer on the VRAM access bus, with a prefetching scan-out stream.
// Optional macro VRAM_BRAM_FB_STREAM_REG_EN registers stream_data_o instead of fall-through.
module vram_bram_fb #(
  parameter int FB_WIDTH      = 160,
  parameter int FB_HEIGHT     = 120,
  parameter int FIFO_DEPTH    = 16,
  parameter int PRELOAD_WORDS = 8,
  parameter int LOW_WATER     = 4
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        sel_i,
  input  logic        wr_i,
  input  logic [3:0]  mask_i,
  input  logic [23:0] address_i,
  input  logic [15:0] data_in_i,
  output logic        ack_o,
  output logic [15:0] data_out_o,
  input  logic        stream_start_frame_i,
  input  logic [23:0] stream_base_address_i,
  input  logic        stream_ena_i,
  output logic [15:0] stream_data_o,
  output logic        stream_preloading_o,
  output logic        stream_err_underflow_o
);

  localparam int N  = FB_WIDTH * FB_HEIGHT;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = PW + 1;
  localparam logic [23:0] N_A = 24'(N);
  localparam logic [24:0] N_C = 25'(N);

  typedef enum logic {B_IDLE, B_ACK} bus_state_e;
  typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_RUN} str_state_e;

  bus_state_e  b_state_q;
  str_state_e  s_state_q;
  logic        rd_q, rd_oob_q;
  logic [15:0] hold_q;
  logic [15:0] ram_q;
  logic [15:0] ram_mem [N];
  logic [15:0] fifo_mem [FIFO_DEPTH];
  logic [23:0] base_q;
  logic [24:0] fcnt_q;
  logic [LW-1:0] level_q, level_d, level_tot;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic        inflight_q, inflight_oob_q, underflow_q;

  logic        start, stream_active, words_left, fetch_low, fetch_room;
  logic        bus_req, grant_bus, grant_fetch, bus_oob, fetch_oob;
  logic        ram_we, push, pop, uflow_evt;
  logic [23:0] fetch_addr;
  logic [AW-1:0] ram_addr;
  logic [15:0] rd_data, fifo_head;
  logic        unused_mask;

  assign unused_mask = ^mask_i[3:2];

  // Arbitration: a starving stream beats the bus, the bus beats a topping-up stream.
  assign start         = stream_start_frame_i;
  assign stream_active = (s_state_q != S_IDLE) && !start;
  assign words_left    = fcnt_q < N_C;
  assign level_tot     = level_q + LW'(inflight_q);
  assign fetch_low     = stream_active && words_left && (level_tot < LW'(LOW_WATER));
  assign fetch_room    = stream_active && words_left && (level_tot < LW'(FIFO_DEPTH));
  assign bus_req       = (b_state_q == B_IDLE) && sel_i;
  assign grant_bus     = bus_req && !fetch_low;
  assign grant_fetch   = fetch_low || (!bus_req && fetch_room);

  assign fetch_addr = base_q + fcnt_q[23:0];
  assign fetch_oob  = fetch_addr >= N_A;
  assign bus_oob    = address_i >= N_A;
  assign ram_addr   = grant_fetch ? fetch_addr[AW-1:0] : address_i[AW-1:0];
  assign ram_we     = grant_bus && wr_i && !bus_oob && !reset;

  always_ff @(posedge clk_pix) begin
    if (ram_we && mask_i[0]) ram_mem[ram_addr][7:0]  <= data_in_i[7:0];
    if (ram_we && mask_i[1]) ram_mem[ram_addr][15:8] <= data_in_i[15:8];
    ram_q <= ram_mem[ram_addr];
  end

  assign rd_data    = rd_oob_q ? 16'h0000 : ram_q;
  assign ack_o      = (b_state_q == B_ACK);
  assign data_out_o = (ack_o && rd_q) ? rd_data : hold_q;

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      b_state_q <= B_IDLE;
      rd_q      <= 1'b0;
      rd_oob_q  <= 1'b0;
      hold_q    <= 16'h0000;
    end else begin
      case (b_state_q)
        B_IDLE: if (grant_bus) begin
          b_state_q <= B_ACK;
          rd_q      <= !wr_i;
          rd_oob_q  <= bus_oob;
        end
        B_ACK: begin
          b_state_q <= B_IDLE;
          if (rd_q) hold_q <= rd_data;
        end
        default: b_state_q <= B_IDLE;
      endcase
    end
  end

  // The word fetched last cycle lands in the FIFO now, unless a start discards it.
  assign push      = inflight_q && !start;
  assign pop       = !start && stream_ena_i && (s_state_q == S_RUN) && (level_q != '0);
  assign uflow_evt = !start && stream_ena_i &&
                     ((s_state_q == S_PRELOAD) || ((s_state_q == S_RUN) && (level_q == '0)));
  assign level_d   = level_q + LW'(push) - LW'(pop);
  assign fifo_head = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk_pix) begin
    if (push) fifo_mem[wr_ptr_q] <= inflight_oob_q ? 16'h0000 : ram_q;
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      s_state_q      <= S_IDLE;
      base_q         <= '0;
      fcnt_q         <= '0;
      level_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_oob_q <= 1'b0;
      underflow_q    <= 1'b0;
    end else if (start) begin
      s_state_q      <= S_PRELOAD;
      base_q         <= stream_base_address_i;
      fcnt_q         <= '0;
      level_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_oob_q <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      inflight_q     <= grant_fetch;
      inflight_oob_q <= fetch_oob;
      level_q        <= level_d;
      if (grant_fetch) fcnt_q <= fcnt_q + 25'd1;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (uflow_evt) underflow_q <= 1'b1;
      case (s_state_q)
        S_IDLE:    s_state_q <= S_IDLE;
        S_PRELOAD: if ((level_q >= LW'(PRELOAD_WORDS)) || (!words_left && !inflight_q))
                     s_state_q <= S_RUN;
        S_RUN:     s_state_q <= S_RUN;
        default:   s_state_q <= S_IDLE;
      endcase
    end
  end

  assign stream_preloading_o    = (s_state_q == S_PRELOAD);
  assign stream_err_underflow_o = underflow_q;

`ifdef VRAM_BRAM_FB_STREAM_REG_EN
  logic [15:0] sdata_q;
  always_ff @(posedge clk_pix) begin
    if (reset) sdata_q <= 16'h0000;
    else if (!start && stream_ena_i && (s_state_q != S_IDLE))
      sdata_q <= pop ? fifo_head : 16'h0000;
  end
  assign stream_data_o = sdata_q;
`else
  assign stream_data_o = (level_q != '0) ? fifo_head : 16'h0000;
`endif

endmodule

// File: tb/tb_vram_bram_fb.sv
// Directed bench for vram_bram_fb: bus vector table plus stream preload/scan/underflow sequences.
module tb_vram_bram_fb;
  localparam int NW = 64;  // 16 x 4 frame

  logic        clk_pix = 1'b0;
  logic        reset = 1'b1;
  logic        sel_i = 1'b0, wr_i = 1'b0;
  logic [3:0]  mask_i = 4'h0;
  logic [23:0] address_i = '0;
  logic [15:0] data_in_i = '0;
  logic        ack_o;
  logic [15:0] data_out_o;
  logic        stream_start_frame_i = 1'b0;
  logic [23:0] stream_base_address_i = '0;
  logic        stream_ena_i = 1'b0;
  logic [15:0] stream_data_o;
  logic        stream_preloading_o, stream_err_underflow_o;

  int total = 0;
  int bad = 0;

  vram_bram_fb #(.FB_WIDTH(16), .FB_HEIGHT(4), .FIFO_DEPTH(16),
                 .PRELOAD_WORDS(8), .LOW_WATER(4)) dut (
    .clk_pix(clk_pix), .reset(reset), .sel_i(sel_i), .wr_i(wr_i), .mask_i(mask_i),
    .address_i(address_i), .data_in_i(data_in_i), .ack_o(ack_o), .data_out_o(data_out_o),
    .stream_start_frame_i(stream_start_frame_i), .stream_base_address_i(stream_base_address_i),
    .stream_ena_i(stream_ena_i), .stream_data_o(stream_data_o),
    .stream_preloading_o(stream_preloading_o), .stream_err_underflow_o(stream_err_underflow_o)
  );

  always #5 clk_pix = ~clk_pix;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic [3:0]  mask;
    logic [23:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic w, input logic [3:0] m, input logic [23:0] a,
                        input logic [15:0] d, output logic [15:0] rd, output int lat);
    sel_i = 1'b1; wr_i = w; mask_i = m; address_i = a; data_in_i = d;
    lat = 0;
    tick(); lat++;
    while (!ack_o && lat < 64) begin tick(); lat++; end
    chk("bus_ack", {31'd0, ack_o}, 32'd1);
    rd = data_out_o;
    sel_i = 1'b0; wr_i = 1'b0;
    $display("bus %s addr=%06h wdata=%04h mask=%0h rdata=%04h lat=%0d",
             w ? "wr" : "rd", a, d, m, rd, lat);
  endtask

  task automatic start_frame(input logic [23:0] base, input logic ena);
    stream_start_frame_i = 1'b1; stream_base_address_i = base; stream_ena_i = ena;
    tick();
    stream_start_frame_i = 1'b0; stream_ena_i = 1'b0;
    $display("start base=%06h ena=%0d", base, ena);
  endtask

  task automatic wait_preload(output int n);
    n = 0;
    while (stream_preloading_o && n < 200) begin tick(); n++; end
    chk("preload_exit", {31'd0, stream_preloading_o}, 32'd0);
  endtask

  // One pop with ena held for a single cycle; checks the popped pixel.
  task automatic pop_check(input string name, input logic [15:0] exp);
    stream_ena_i = 1'b1;
`ifdef VRAM_BRAM_FB_STREAM_REG_EN
    tick();
    chk(name, {16'd0, stream_data_o}, {16'd0, exp});
`else
    chk(name, {16'd0, stream_data_o}, {16'd0, exp});
    tick();
`endif
  endtask

  vec_t vecs[18];
  logic [15:0] rd;
  int lat, n;
  logic a_done;

  initial begin
    vecs[0]  = '{1'b1, 4'h3, 24'h000005, 16'hABCD, 16'h0000};
    vecs[1]  = '{1'b0, 4'h3, 24'h000005, 16'h0000, 16'hABCD};
    vecs[2]  = '{1'b1, 4'h3, 24'h000007, 16'h1234, 16'h0000};
    vecs[3]  = '{1'b1, 4'h1, 24'h000007, 16'hFF56, 16'h0000};
    vecs[4]  = '{1'b0, 4'h3, 24'h000007, 16'h0000, 16'h1256};
    vecs[5]  = '{1'b1, 4'h2, 24'h000007, 16'hAA99, 16'h0000};
    vecs[6]  = '{1'b0, 4'h3, 24'h000007, 16'h0000, 16'hAA56};
    vecs[7]  = '{1'b1, 4'h0, 24'h000005, 16'hFFFF, 16'h0000};
    vecs[8]  = '{1'b1, 4'hC, 24'h000005, 16'hFFFF, 16'h0000};
    vecs[9]  = '{1'b0, 4'h3, 24'h000005, 16'h0000, 16'hABCD};
    vecs[10] = '{1'b1, 4'h3, 24'h000000, 16'h5A5A, 16'h0000};
    vecs[11] = '{1'b0, 4'h3, 24'h100000, 16'h0000, 16'h0000};
    vecs[12] = '{1'b1, 4'h3, 24'h100000, 16'hDEAD, 16'h0000};
    vecs[13] = '{1'b1, 4'h3, 24'h000040, 16'h1111, 16'h0000};
    vecs[14] = '{1'b0, 4'h3, 24'h000000, 16'h0000, 16'h5A5A};
    vecs[15] = '{1'b1, 4'h3, 24'h00003F, 16'hBEEF, 16'h0000};
    vecs[16] = '{1'b0, 4'h3, 24'h00003F, 16'h0000, 16'hBEEF};
    vecs[17] = '{1'b0, 4'h3, 24'h000040, 16'h0000, 16'h0000};

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_data_out", {16'd0, data_out_o}, 32'd0);
    chk("rst_stream_data", {16'd0, stream_data_o}, 32'd0);
    chk("rst_preloading", {31'd0, stream_preloading_o}, 32'd0);
    chk("rst_underflow", {31'd0, stream_err_underflow_o}, 32'd0);

    // Bus table: idle stream, so each access is granted on the first edge.
    for (int i = 0; i < 18; i++) begin
      tick();
      bus_op(vecs[i].wr, vecs[i].mask, vecs[i].addr, vecs[i].data, rd, lat);
      chk($sformatf("vec%0d_lat", i), lat, 32'd1);
      if (!vecs[i].wr) begin
        chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp});
        tick();
        chk($sformatf("vec%0d_hold", i), {16'd0, data_out_o}, {16'd0, vecs[i].exp});
      end
    end

    for (int i = 0; i < NW; i++) begin
      tick();
      bus_op(1'b1, 4'h3, 24'(i), 16'(i), rd, lat);
    end
    tick();

    // Fetch issued right after start lands a cycle later, so level 8 is reached
    // nine edges after start and the state leaves preload on the tenth.
    start_frame(24'd0, 1'b0);
    chk("preload_rise", {31'd0, stream_preloading_o}, 32'd1);
    wait_preload(n);
    chk("preload_cycles", n, 32'd10);
    for (int i = 0; i < NW; i++) pop_check($sformatf("scan%0d", i), 16'(i));
    stream_ena_i = 1'b0;
    chk("scan_no_underflow", {31'd0, stream_err_underflow_o}, 32'd0);

    start_frame(24'd0, 1'b0);
    stream_ena_i = 1'b1;
    tick();
    stream_ena_i = 1'b0;
    chk("underflow_set", {31'd0, stream_err_underflow_o}, 32'd1);
    repeat (3) tick();
    chk("underflow_sticky", {31'd0, stream_err_underflow_o}, 32'd1);
    start_frame(24'd0, 1'b1);
    chk("underflow_cleared", {31'd0, stream_err_underflow_o}, 32'd0);
    wait_preload(n);

    // A single port cannot serve a pixel every cycle and the bus at once, so
    // scan-out here consumes every other cycle while the bus reads back to back.
    a_done = 1'b0;
    fork
      begin
        for (int i = 0; i < NW; i++) begin
          pop_check($sformatf("mix_scan%0d", i), 16'(i));
          stream_ena_i = 1'b0;
          tick();
        end
        a_done = 1'b1;
      end
      begin
        for (int k = 0; k < 200 && !a_done; k++) begin
          bus_op(1'b0, 4'h3, 24'((k * 7) % NW), 16'h0, rd, lat);
          chk($sformatf("mix_rd%0d", k), {16'd0, rd}, 32'((k * 7) % NW));
          chk($sformatf("mix_lat%0d", k), {31'd0, (lat <= 16)}, 32'd1);
          tick();
        end
      end
    join
    chk("mix_no_underflow", {31'd0, stream_err_underflow_o}, 32'd0);

    // Frame running past the end of memory reads zeros beyond word N-1.
    start_frame(24'd60, 1'b0);
    wait_preload(n);
    pop_check("tail60", 16'd60);
    pop_check("tail61", 16'd61);
    pop_check("tail62", 16'd62);
    pop_check("tail63", 16'd63);
    pop_check("tail_oob0", 16'd0);
    pop_check("tail_oob1", 16'd0);
    stream_ena_i = 1'b0;
    chk("tail_no_underflow", {31'd0, stream_err_underflow_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
